// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES helpers: GF(2^8) doubling/tripling and byte
//               indexing for the FIPS-197 column-major 128-bit state.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Reduction constant for multiplication by x in GF(2^8)
  localparam logic [7:0] c_GF_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? c_GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // Byte number of (row, col) in column-major order
  function automatic int byte_idx(input int row, input int col);
    return 4 * col + row;
  endfunction

  // MSB position of byte b inside the 128-bit state
  function automatic int byte_msb(input int b);
    return 127 - 8 * b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/add_round_key.sv
`default_nettype none
// ============================================================================
// Module      : add_round_key
// Description : Registered AddRoundKey stage. An active byte load drops the
//               data presented that cycle rather than stalling it.
// Revision    : 1.0 - initial release
// ============================================================================
module add_round_key
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         load,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         done
);

  logic [127:0] r_out;
  logic         r_done;

  // Stage register: key XOR when enabled and no load in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_done <= 1'b0;
    end else if (enable && !load) begin
      r_out  <= in ^ key;
      r_done <= 1'b1;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign out  = r_out;
  assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/mix_columns.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns
// Description : Registered MixColumns stage with a final-round bypass that
//               still spends one cycle so pipeline latency is constant.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_columns
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         bypass,
  input  logic [127:0] in,
  output logic [127:0] out,
  output logic         done
);

  logic [127:0] w_mixed;
  logic [127:0] r_out;
  logic         r_done;

  // Each column is an independent 4-byte matrix multiply over GF(2^8)
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = in[byte_msb(byte_idx(0, c)) -: 8];
    assign w_a1 = in[byte_msb(byte_idx(1, c)) -: 8];
    assign w_a2 = in[byte_msb(byte_idx(2, c)) -: 8];
    assign w_a3 = in[byte_msb(byte_idx(3, c)) -: 8];
    assign w_mixed[byte_msb(byte_idx(0, c)) -: 8] =
      xtime(w_a0) ^ gf_mul3(w_a1) ^ w_a2 ^ w_a3;
    assign w_mixed[byte_msb(byte_idx(1, c)) -: 8] =
      w_a0 ^ xtime(w_a1) ^ gf_mul3(w_a2) ^ w_a3;
    assign w_mixed[byte_msb(byte_idx(2, c)) -: 8] =
      w_a0 ^ w_a1 ^ xtime(w_a2) ^ gf_mul3(w_a3);
    assign w_mixed[byte_msb(byte_idx(3, c)) -: 8] =
      gf_mul3(w_a0) ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

  // Stage register: mixed or bypassed data on enable, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_done <= 1'b0;
    end else if (enable) begin
      r_out  <= bypass ? in : w_mixed;
      r_done <= 1'b1;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign out  = r_out;
  assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/shift_rows.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows
// Description : Registered ShiftRows stage; row r rotated left by r bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rows
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [127:0] in,
  output logic [127:0] out,
  output logic         done
);

  logic [127:0] w_shifted;
  logic [127:0] r_out;
  logic         r_done;

  // Output byte (r,c) takes input byte (r,(c+r) mod 4); pure wiring
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int c_DST = byte_msb(byte_idx(r, c));
      localparam int c_SRC = byte_msb(byte_idx(r, (c + r) % 4));
      assign w_shifted[c_DST -: 8] = in[c_SRC -: 8];
    end
  end

  // Stage register: capture on enable, otherwise hold data and drop done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_done <= 1'b0;
    end else if (enable) begin
      r_out  <= w_shifted;
      r_done <= 1'b1;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign out  = r_out;
  assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/aes_round_ops.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ops
// Description : AES-128 linear round datapath: ShiftRows -> MixColumns ->
//               AddRoundKey, one registered stage each, 3-cycle latency.
//               final_round is consumed one cycle and round_key/load two
//               cycles after state_in, matching the stage they feed.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ops
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         enable,
  input  logic         load,
  input  logic         final_round,
  output logic [127:0] state_out,
  output logic         done
);

  logic [127:0] w_sr_out;
  logic         w_sr_done;
  logic [127:0] w_mc_out;
  logic         w_mc_done;

  shift_rows u_shift_rows (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .in     (state_in),
    .out    (w_sr_out),
    .done   (w_sr_done)
  );

  mix_columns u_mix_columns (
    .clk    (clk),
    .rst    (rst),
    .enable (w_sr_done),
    .bypass (final_round),
    .in     (w_sr_out),
    .out    (w_mc_out),
    .done   (w_mc_done)
  );

  add_round_key u_add_round_key (
    .clk    (clk),
    .rst    (rst),
    .enable (w_mc_done),
    .load   (load),
    .in     (w_mc_out),
    .key    (round_key),
    .out    (state_out),
    .done   (done)
  );

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ops.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_ops
// Description : Scoreboard bench for aes_round_ops with a byte-array AES
//               reference model, directed FIPS-197 vectors and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ops;

  localparam int NE = 400;

  logic         clk;
  logic         rst;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         enable;
  logic         load;
  logic         final_round;
  logic [127:0] state_out;
  logic         done;

  aes_round_ops dut (
    .clk         (clk),
    .rst         (rst),
    .state_in    (state_in),
    .round_key   (round_key),
    .enable      (enable),
    .load        (load),
    .final_round (final_round),
    .state_out   (state_out),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [127:0] val;
  } exp_t;

  exp_t         q[$];
  int           vectors = 0;
  int           miscompares = 0;

  // Per-item plan: index = cycle in which state_in is presented
  logic         p_rs  [NE+3];
  logic         p_en  [NE+3];
  logic         p_fr  [NE+3];
  logic         p_ld  [NE+3];
  logic [127:0] p_st  [NE+3];
  logic [127:0] p_key [NE+3];
  logic         p_lit [NE+3];
  logic [127:0] p_litv[NE+3];

  localparam int MC[16] = '{2, 3, 1, 1,
                            1, 2, 3, 1,
                            1, 1, 2, 3,
                            3, 1, 1, 2};

  // Generic GF(2^8) multiply by shift-and-add
  function automatic logic [7:0] gmul(input logic [7:0] a, input int m);
    logic [8:0] p;
    logic [7:0] r;
    r = 8'h00;
    p = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r = r ^ p[7:0];
      p = p << 1;
      if (p[8]) p = p ^ 9'h11b;
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] st,
                                             input logic [127:0] key,
                                             input logic fr);
    logic [7:0] s[16];
    logic [7:0] t[16];
    logic [7:0] u[16];
    logic [127:0] res;
    for (int b = 0; b < 16; b++) s[b] = st[127-8*b -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = s[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        u[r+4*c] = 8'h00;
        for (int k = 0; k < 4; k++)
          u[r+4*c] = u[r+4*c] ^ gmul(t[k+4*c], MC[4*r+k]);
      end
    for (int b = 0; b < 16; b++)
      res[127-8*b -: 8] = (fr ? t[b] : u[b]) ^ key[127-8*b -: 8];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Driver: build plan, then present one cycle at a time
  initial begin
    for (int k = 0; k < NE + 3; k++) begin
      p_rs[k]   = ($urandom_range(0, 99) < 2);
      p_en[k]   = ($urandom_range(0, 99) < 80);
      p_fr[k]   = $urandom_range(0, 1) == 1;
      p_ld[k]   = ($urandom_range(0, 99) < 10);
      p_st[k]   = rnd128();
      p_key[k]  = rnd128();
      p_lit[k]  = 1'b0;
      p_litv[k] = '0;
      if (k < 16) p_rs[k] = 1'b0;
      if (k >= NE - 3) begin
        p_en[k] = 1'b0;
        p_rs[k] = 1'b0;
      end
    end
    // Reset held with enable high
    for (int k = 0; k < 4; k++) begin
      p_rs[k] = 1'b1;
      p_en[k] = 1'b1;
    end
    // Directed back-to-back vectors
    for (int k = 4; k < 8; k++) begin
      p_en[k]  = 1'b1;
      p_ld[k]  = 1'b0;
      p_lit[k] = 1'b1;
    end
    p_st[4] = 128'hd42711aee0bf98f1b8b45de51e415230;
    p_key[4] = 128'ha0fafe1788542cb123a339392a6c7605;
    p_fr[4] = 1'b0;
    p_litv[4] = 128'ha49c7ff2689f352b6b5bea43026a5049;
    p_st[5] = 128'hd42711aee0bf98f1b8b45de51e415230;
    p_key[5] = 128'ha0fafe1788542cb123a339392a6c7605;
    p_fr[5] = 1'b1;
    p_litv[5] = 128'hd4bf5d30e0b452aeb84111f11e2798e5 ^ 128'ha0fafe1788542cb123a339392a6c7605;
    p_st[6] = 128'hd42711aee0bf98f1b8b45de51e415230;
    p_key[6] = '0;
    p_fr[6] = 1'b0;
    p_litv[6] = 128'h046681e5e0cb199a48f8d37a2806264c;
    p_st[7] = 128'hdb000000_0013_0000_0000_5300_00000045;
    p_key[7] = '0;
    p_fr[7] = 1'b0;
    p_litv[7] = 128'h8e4da1bc000000000000000000000000;
    // One-cycle enable gap, then an item dropped by load
    p_en[8] = 1'b0;
    p_en[9] = 1'b1;
    p_ld[9] = 1'b1;
    p_en[10] = 1'b1;
    p_ld[10] = 1'b0;

    for (int k = 0; k < NE; k++) begin
      rst         = p_rs[k];
      enable      = p_en[k];
      state_in    = p_st[k];
      final_round = (k >= 1) ? p_fr[k-1] : 1'b0;
      round_key   = (k >= 2) ? p_key[k-2] : '0;
      load        = (k >= 2) ? p_ld[k-2] : 1'b0;
      if (p_en[k] && !p_rs[k] && !p_rs[k+1] && !p_rs[k+2] && !p_ld[k])
        q.push_back('{cyc: k + 2,
                      val: p_lit[k] ? p_litv[k] : ref_round(p_st[k], p_key[k], p_fr[k])});
      @(posedge clk);
      #2;
    end
    @(posedge clk);
    #3;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d results outstanding, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: check done and state_out after every edge
  initial begin
    logic [127:0] held;
    logic [127:0] exp_o;
    logic         exp_d;
    held = '0;
    for (int k = 0; k < NE; k++) begin
      @(posedge clk);
      #1;
      if (p_rs[k]) begin
        held  = '0;
        exp_o = '0;
        exp_d = 1'b0;
      end else if (q.size() != 0 && q[0].cyc == k) begin
        exp_o = q[0].val;
        exp_d = 1'b1;
        held  = q[0].val;
        void'(q.pop_front());
      end else begin
        exp_o = held;
        exp_d = 1'b0;
      end
      vectors++;
      if (done !== exp_d || state_out !== exp_o) begin
        miscompares++;
        $display("FAIL cyc%0d round: got done=%0b out=%h, want done=%0b out=%h",
                 k, done, state_out, exp_d, exp_o);
      end
    end
  end

endmodule
`default_nettype wire
